// File: rtl/alu_decoder.sv
// MIPS ALU control: maps main-decoder aluop plus funct to an ALU code.
// Combinational output for the ALU, plus a registered copy with valid/illegal.
module alu_decoder #(
  parameter logic [2:0] ADD         = 3'b010,
  parameter logic [2:0] SUBT        = 3'b110,
  parameter logic [2:0] AND         = 3'b000,
  parameter logic [2:0] OR          = 3'b001,
  parameter logic [2:0] SETLESSTHAN = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  input  logic       in_valid,
  output logic [2:0] aluControl,
  output logic [2:0] aluControl_q,
  output logic       out_valid,
  output logic       illegal_q
);

  logic       w_illegal;
  logic [2:0] r_ctrl;
  logic       r_valid;
  logic       r_illegal;

  always_comb begin
    aluControl = ADD;
    w_illegal  = 1'b0;
    case (aluop)
      2'b00: aluControl = ADD;
      2'b01: aluControl = SUBT;
      2'b10: begin
        case (funct)
          6'b100000: aluControl = ADD;
          6'b100001: aluControl = ADD;
          6'b100010: aluControl = SUBT;
          6'b100011: aluControl = SUBT;
          6'b100100: aluControl = AND;
          6'b100101: aluControl = OR;
          6'b101010: aluControl = SETLESSTHAN;
          default: begin
            aluControl = ADD;
            w_illegal  = 1'b1;
          end
        endcase
      end
      default: begin
        // aluop 2'b11 is reserved by the main decoder
        aluControl = ADD;
        w_illegal  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl    <= ADD;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_ctrl    <= aluControl;
        r_illegal <= w_illegal;
      end
    end
  end

  assign aluControl_q = r_ctrl;
  assign out_valid    = r_valid;
  assign illegal_q    = r_illegal;

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed literals plus
// randomized stimulus against a table-driven reference model.
module tb_alu_decoder;

  logic       clk;
  logic       reset;
  logic [1:0] aluop;
  logic [5:0] funct;
  logic       in_valid;
  logic [2:0] aluControl;
  logic [2:0] aluControl_q;
  logic       out_valid;
  logic       illegal_q;

  alu_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .aluop        (aluop),
    .funct        (funct),
    .in_valid     (in_valid),
    .aluControl   (aluControl),
    .aluControl_q (aluControl_q),
    .out_valid    (out_valid),
    .illegal_q    (illegal_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [2:0] exp_q;
  logic       exp_v;
  logic       exp_ill;

  // R-type funct -> ALU code table
  logic [2:0] rtab [bit [5:0]];
  bit [5:0] legal [7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a};

  initial begin
    rtab[6'h20] = 3'b010;
    rtab[6'h21] = 3'b010;
    rtab[6'h22] = 3'b110;
    rtab[6'h23] = 3'b110;
    rtab[6'h24] = 3'b000;
    rtab[6'h25] = 3'b001;
    rtab[6'h2a] = 3'b111;
  end

  // returns {illegal, code}
  function automatic logic [3:0] model(input logic [1:0] op,
                                       input logic [5:0] f);
    if (op == 2'd0) return {1'b0, 3'b010};
    if (op == 2'd1) return {1'b0, 3'b110};
    if (op == 2'd2 && rtab.exists(f)) return {1'b0, rtab[f]};
    return {1'b1, 3'b010};
  endfunction

  task automatic chk(input string name, input logic [2:0] act,
                     input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] m;
      m = model(aluop, funct);
      chk("cmp_comb", aluControl, m[2:0]);
      chk("cmp_q", aluControl_q, exp_q);
      chk("cmp_valid", {2'b0, out_valid}, {2'b0, exp_v});
      chk("cmp_illegal", {2'b0, illegal_q}, {2'b0, exp_ill});
    end
  end

  task automatic drive(input logic [1:0] op, input logic [5:0] f,
                       input logic v);
    aluop    = op;
    funct    = f;
    in_valid = v;
  endtask

  task automatic tick();
    logic [3:0] m;
    m = model(aluop, funct);
    @(posedge clk);
    #1;
    exp_v = in_valid;
    if (in_valid) begin
      exp_q   = m[2:0];
      exp_ill = m[3];
    end
  endtask

  task automatic comb_lit(input string name, input logic [1:0] op,
                          input logic [5:0] f, input logic [2:0] e);
    drive(op, f, 1'b1);
    #2;
    chk(name, aluControl, e);
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    exp_q   = 3'b010;
    exp_v   = 1'b0;
    exp_ill = 1'b0;
    chk("rst_q", aluControl_q, 3'b010);
    chk("rst_valid", {2'b0, out_valid}, 3'b000);
    chk("rst_ill", {2'b0, illegal_q}, 3'b000);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(2'd0, 6'd0, 1'b0);
    #3;
    exp_q   = 3'b010;
    exp_v   = 1'b0;
    exp_ill = 1'b0;
    chk("init_q", aluControl_q, 3'b010);
    chk("init_valid", {2'b0, out_valid}, 3'b000);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    comb_lit("lw_add", 2'd0, 6'h00, 3'b010);
    comb_lit("beq_sub", 2'd1, 6'h00, 3'b110);
    comb_lit("lw_fignore", 2'd0, 6'h2a, 3'b010);
    comb_lit("beq_fignore", 2'd1, 6'h2a, 3'b110);
    comb_lit("r_add", 2'd2, 6'h20, 3'b010);
    comb_lit("r_sub", 2'd2, 6'h22, 3'b110);
    comb_lit("r_and", 2'd2, 6'h24, 3'b000);
    comb_lit("r_or", 2'd2, 6'h25, 3'b001);
    comb_lit("r_slt", 2'd2, 6'h2a, 3'b111);
    comb_lit("r_addu", 2'd2, 6'h21, 3'b010);
    comb_lit("r_subu", 2'd2, 6'h23, 3'b110);

    comb_lit("r_bad", 2'd2, 6'h00, 3'b010);
    chk("r_bad_illq", {2'b0, illegal_q}, 3'b001);
    comb_lit("op11", 2'd3, 6'h24, 3'b010);
    chk("op11_illq", {2'b0, illegal_q}, 3'b001);

    pulse_reset();
    drive(2'd2, 6'h2a, 1'b1);
    tick();
    chk("post_rst_q", aluControl_q, 3'b111);
    chk("post_rst_v", {2'b0, out_valid}, 3'b001);
    chk("post_rst_ill", {2'b0, illegal_q}, 3'b000);

    drive(2'd2, 6'h2a, 1'b1);
    tick();
    chk("pipe_slt", aluControl_q, 3'b111);
    drive(2'd2, 6'h24, 1'b1);
    tick();
    chk("pipe_and", aluControl_q, 3'b000);
    drive(2'd2, 6'h25, 1'b1);
    tick();
    chk("pipe_or", aluControl_q, 3'b001);
    chk("pipe_or_v", {2'b0, out_valid}, 3'b001);
    drive(2'd2, 6'h22, 1'b0);
    tick();
    chk("pipe_hold", aluControl_q, 3'b001);
    chk("pipe_hold_v", {2'b0, out_valid}, 3'b000);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] f;
      if ($urandom_range(1, 0) == 1) f = legal[$urandom_range(6, 0)];
      else f = 6'($urandom);
      drive(2'($urandom), f, 1'($urandom));
      if ($urandom_range(49, 0) == 0) pulse_reset();
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
